// File: rtl/hwacc_tcdm_responder.sv
// TCDM responder: round-robin arbitration of N_PORT TCDM masters onto one
// single-port SRAM with a fixed one-cycle response path.
module hwacc_tcdm_responder #(
    parameter int          N_PORT         = 4,
    parameter int          MEM_ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h1C01_0000,
    parameter logic [31:0] ERR_DATA       = 32'hBADA_CCE5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_PORT-1:0]            tcdm_req_i,
    input  logic [N_PORT-1:0][31:0]      tcdm_add_i,
    input  logic [N_PORT-1:0]            tcdm_wen_i,
    input  logic [N_PORT-1:0][3:0]       tcdm_be_i,
    input  logic [N_PORT-1:0][31:0]      tcdm_wdata_i,
    output logic [N_PORT-1:0]            tcdm_gnt_o,
    output logic [N_PORT-1:0]            tcdm_r_valid_o,
    output logic [N_PORT-1:0][31:0]      tcdm_r_rdata_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [3:0]                   mem_be_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i,
    output logic                         err_o
);

    localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    // 33-bit bounds so a window ending at 2**32 never wraps into range.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << MEM_ADDR_WIDTH);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] ptr_next;
    logic             any_req;
    logic [31:0]      win_add;
    logic             in_window;

    logic             resp_valid;
    logic [PTR_W-1:0] resp_idx;
    logic             resp_err;
    logic             resp_read;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_PORT; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % N_PORT);
            if (!any_req && tcdm_req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign ptr_next  = (winner == PTR_W'(N_PORT - 1)) ? '0 : winner + 1'b1;
    assign win_add   = tcdm_add_i[winner];
    assign in_window = ({1'b0, win_add} >= WIN_LO) && ({1'b0, win_add} < WIN_HI);

    always_comb begin
        tcdm_gnt_o = '0;
        if (any_req && !rst_i) begin
            tcdm_gnt_o[winner] = 1'b1;
        end
    end

    assign mem_req_o   = any_req && in_window && !rst_i;
    assign mem_we_o    = ~tcdm_wen_i[winner];
    assign mem_addr_o  = MEM_ADDR_WIDTH'((win_add - BASE_ADDR) >> 2);
    assign mem_be_o    = tcdm_be_i[winner];
    assign mem_wdata_o = tcdm_wdata_i[winner];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            resp_err   <= 1'b0;
            resp_read  <= 1'b0;
        end else begin
            resp_valid <= any_req;
            if (any_req) begin
                rr_ptr    <= ptr_next;
                resp_idx  <= winner;
                resp_err  <= ~in_window;
                resp_read <= tcdm_wen_i[winner];
            end
        end
    end

    // Gating with rst_i drops a response that falls due in the reset cycle.
    always_comb begin
        tcdm_r_valid_o = '0;
        tcdm_r_rdata_o = '0;
        if (resp_valid && !rst_i) begin
            tcdm_r_valid_o[resp_idx] = 1'b1;
            if (resp_read) begin
                tcdm_r_rdata_o[resp_idx] = resp_err ? ERR_DATA : mem_rdata_i;
            end
        end
    end

    assign err_o = resp_valid && resp_err && !rst_i;

endmodule

// File: tb/tb_hwacc_tcdm_responder.sv
// Directed bench for hwacc_tcdm_responder with a behavioural 4096x32 SRAM
// attached to the memory port.
module tb_hwacc_tcdm_responder;

    localparam logic [31:0] BASE = 32'h1C01_0000;
    localparam logic [31:0] ERRD = 32'hBADA_CCE5;

    logic             clk;
    logic             rst;
    logic [3:0]       tcdm_req;
    logic [3:0][31:0] tcdm_add;
    logic [3:0]       tcdm_wen;
    logic [3:0][3:0]  tcdm_be;
    logic [3:0][31:0] tcdm_wdata;
    logic [3:0]       tcdm_gnt;
    logic [3:0]       tcdm_r_valid;
    logic [3:0][31:0] tcdm_r_rdata;
    logic             mem_req;
    logic             mem_we;
    logic [11:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             err;

    logic [31:0]      sram [0:4095];
    logic [31:0]      exp_word [4];

    int n_checks;
    int n_fail;

    hwacc_tcdm_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tcdm_req_i     (tcdm_req),
        .tcdm_add_i     (tcdm_add),
        .tcdm_wen_i     (tcdm_wen),
        .tcdm_be_i      (tcdm_be),
        .tcdm_wdata_i   (tcdm_wdata),
        .tcdm_gnt_o     (tcdm_gnt),
        .tcdm_r_valid_o (tcdm_r_valid),
        .tcdm_r_rdata_o (tcdm_r_rdata),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: byte-masked writes, read data one cycle after req.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic clearReqs();
        tcdm_req   = '0;
        tcdm_add   = '0;
        tcdm_wen   = '1;
        tcdm_be    = '0;
        tcdm_wdata = '0;
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] add, input logic wen,
                                 input logic [3:0] be, input logic [31:0] wdata);
        tcdm_req[p]   = 1'b1;
        tcdm_add[p]   = add;
        tcdm_wen[p]   = wen;
        tcdm_be[p]    = be;
        tcdm_wdata[p] = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) sram[i] = '0;
        sram[1] = 32'h1111_0001;
        sram[2] = 32'h2222_0002;
        sram[3] = 32'h3333_0003;
        sram[4] = 32'hCAFE_0004;
        exp_word[0] = 32'h00BB_00DD;
        exp_word[1] = 32'h1111_0001;
        exp_word[2] = 32'h2222_0002;
        exp_word[3] = 32'h3333_0003;

        rst = 1'b1;
        clearReqs();
        @(negedge clk);
        @(negedge clk);
        applyStimulus(0, BASE, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("gnt_in_reset", 32'(tcdm_gnt), 32'h0);
        checkOutput("mem_req_in_reset", 32'(mem_req), 32'h0);
        @(negedge clk);
        checkOutput("rvalid_reset", 32'(tcdm_r_valid), 32'h0);
        checkOutput("rdata0_reset", tcdm_r_rdata[0], 32'h0);
        checkOutput("err_reset", 32'(err), 32'h0);
        rst = 1'b0;
        clearReqs();

        $display("[TB] single read");
        applyStimulus(2, 32'h1C01_0010, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rd_gnt", 32'(tcdm_gnt), 32'h4);
        checkOutput("rd_mem_req", 32'(mem_req), 32'h1);
        checkOutput("rd_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h4);
        @(negedge clk);
        checkOutput("rd_rvalid", 32'(tcdm_r_valid), 32'h4);
        checkOutput("rd_rdata2", tcdm_r_rdata[2], 32'hCAFE_0004);
        checkOutput("rd_rdata0_idle", tcdm_r_rdata[0], 32'h0);
        checkOutput("rd_err", 32'(err), 32'h0);

        $display("[TB] byte write then read");
        clearReqs();
        applyStimulus(0, BASE, 1'b0, 4'b0101, 32'hAABB_CCDD);
        #1;
        checkOutput("wr_gnt", 32'(tcdm_gnt), 32'h1);
        checkOutput("wr_mem_we", 32'(mem_we), 32'h1);
        checkOutput("wr_mem_be", 32'(mem_be), 32'h5);
        checkOutput("wr_mem_wdata", mem_wdata, 32'hAABB_CCDD);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        checkOutput("wr_rvalid", 32'(tcdm_r_valid), 32'h1);
        checkOutput("wr_rdata", tcdm_r_rdata[0], 32'h0);
        clearReqs();
        applyStimulus(0, BASE, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rb_gnt", 32'(tcdm_gnt), 32'h1);
        @(negedge clk);
        checkOutput("rb_rvalid", 32'(tcdm_r_valid), 32'h1);
        checkOutput("rb_rdata", tcdm_r_rdata[0], 32'h00BB_00DD);

        $display("[TB] out-of-window accesses");
        clearReqs();
        applyStimulus(1, 32'h1C01_4000, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("oow_rd_gnt", 32'(tcdm_gnt), 32'h2);
        checkOutput("oow_rd_mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        checkOutput("oow_rd_rvalid", 32'(tcdm_r_valid), 32'h2);
        checkOutput("oow_rd_rdata", tcdm_r_rdata[1], ERRD);
        checkOutput("oow_rd_err", 32'(err), 32'h1);
        clearReqs();
        applyStimulus(2, 32'h1C00_FFFC, 1'b0, 4'hF, 32'h1234_5678);
        #1;
        checkOutput("oow_wr_gnt", 32'(tcdm_gnt), 32'h4);
        checkOutput("oow_wr_mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        checkOutput("oow_wr_rvalid", 32'(tcdm_r_valid), 32'h4);
        checkOutput("oow_wr_rdata", tcdm_r_rdata[2], 32'h0);
        checkOutput("oow_wr_err", 32'(err), 32'h1);
        clearReqs();
        applyStimulus(3, 32'h1C01_3FFC, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("top_gnt", 32'(tcdm_gnt), 32'h8);
        checkOutput("top_mem_req", 32'(mem_req), 32'h1);
        checkOutput("top_mem_addr", 32'(mem_addr), 32'hFFF);
        @(negedge clk);
        checkOutput("top_rvalid", 32'(tcdm_r_valid), 32'h8);
        checkOutput("top_rdata_unchanged", tcdm_r_rdata[3], 32'h0);
        checkOutput("top_err", 32'(err), 32'h0);

        $display("[TB] round-robin fairness from reset");
        clearReqs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 4; p++) applyStimulus(p, BASE + 32'(4 * p), 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rr_gnt_0", 32'(tcdm_gnt), 32'h1);
        checkOutput("rr_addr_0", 32'(mem_addr), 32'h0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rr_rvalid", 32'(tcdm_r_valid), 32'(1) << ((k - 1) % 4));
            checkOutput("rr_rdata", tcdm_r_rdata[(k - 1) % 4], exp_word[(k - 1) % 4]);
            #1;
            checkOutput("rr_gnt", 32'(tcdm_gnt), 32'(1) << (k % 4));
            checkOutput("rr_mem_req", 32'(mem_req), 32'h1);
            checkOutput("rr_addr", 32'(mem_addr), 32'(k % 4));
        end
        @(negedge clk);
        checkOutput("rr_rvalid_last", 32'(tcdm_r_valid), 32'h8);
        checkOutput("rr_rdata_last", tcdm_r_rdata[3], 32'h3333_0003);

        $display("[TB] reset mid-operation");
        clearReqs();
        applyStimulus(3, BASE + 32'hC, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rst3_gnt", 32'(tcdm_gnt), 32'h8);
        @(negedge clk);
        clearReqs();
        rst = 1'b1;
        #1;
        checkOutput("rst3_rvalid_in_reset", 32'(tcdm_r_valid), 32'h0);
        checkOutput("rst3_rdata_in_reset", tcdm_r_rdata[3], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst3_rvalid_after", 32'(tcdm_r_valid), 32'h0);
        applyStimulus(1, BASE + 32'h4, 1'b1, 4'hF, 32'h0);
        applyStimulus(3, BASE + 32'hC, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rst3_gnt_p1_first", 32'(tcdm_gnt), 32'h2);
        @(negedge clk);
        checkOutput("rst3_rvalid_p1", 32'(tcdm_r_valid), 32'h2);
        tcdm_req[1] = 1'b0;
        #1;
        checkOutput("rst3_gnt_p3", 32'(tcdm_gnt), 32'h8);
        @(negedge clk);
        checkOutput("rst3_rdata_p3", tcdm_r_rdata[3], 32'h3333_0003);
        clearReqs();
        applyStimulus(1, BASE + 32'h4, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rst1_gnt", 32'(tcdm_gnt), 32'h2);
        @(negedge clk);
        clearReqs();
        rst = 1'b1;
        #1;
        checkOutput("rst1_rvalid_in_reset", 32'(tcdm_r_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, BASE + 32'h4, 1'b1, 4'hF, 32'h0);
        applyStimulus(3, BASE + 32'hC, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("rst1_ptr_cleared_gnt", 32'(tcdm_gnt), 32'h2);
        @(negedge clk);
        checkOutput("rst1_rvalid_p1", 32'(tcdm_r_valid), 32'h2);
        tcdm_req[1] = 1'b0;
        @(negedge clk);
        checkOutput("rst1_rvalid_p3", 32'(tcdm_r_valid), 32'h8);

        $display("[TB] held loser");
        clearReqs();
        applyStimulus(0, BASE + 32'h8, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("hl_setup_gnt", 32'(tcdm_gnt), 32'h1);
        @(negedge clk);
        checkOutput("hl_setup_rdata", tcdm_r_rdata[0], 32'h2222_0002);
        applyStimulus(1, BASE + 32'hC, 1'b1, 4'hF, 32'h0);
        #1;
        checkOutput("hl_gnt_p1", 32'(tcdm_gnt), 32'h2);
        checkOutput("hl_addr_p1", 32'(mem_addr), 32'h3);
        @(negedge clk);
        checkOutput("hl_rvalid_p1", 32'(tcdm_r_valid), 32'h2);
        checkOutput("hl_rdata_p1", tcdm_r_rdata[1], 32'h3333_0003);
        tcdm_req[1] = 1'b0;
        #1;
        checkOutput("hl_gnt_p0", 32'(tcdm_gnt), 32'h1);
        checkOutput("hl_addr_p0", 32'(mem_addr), 32'h2);
        @(negedge clk);
        checkOutput("hl_rvalid_p0", 32'(tcdm_r_valid), 32'h1);
        checkOutput("hl_rdata_p0", tcdm_r_rdata[0], 32'h2222_0002);
        checkOutput("hl_rdata_p1_quiet", tcdm_r_rdata[1], 32'h0);
        clearReqs();
        @(negedge clk);
        checkOutput("idle_rvalid", 32'(tcdm_r_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hwacc_tcdm_responder.md
Name: hwacc_tcdm_responder

Overview:
- TCDM-side responder (slave) for the hardware-accelerator master ports: accepts N_PORT TCDM requests (req/add/wen/be/wdata), arbitrates them round-robin onto one single-port SRAM and returns gnt, r_valid and r_rdata.
- Terminates the accelerator's data ports in standalone FC-subsystem configurations and benches. It is the memory end of the accelerator's TCDM master interface.

Parameters:
- N_PORT, 4, number of TCDM master ports served
- MEM_ADDR_WIDTH, 12, SRAM word-address width (depth = 2**MEM_ADDR_WIDTH 32-bit words)
- BASE_ADDR, 32'h1C01_0000, byte base address of the window
- ERR_DATA, 32'hBADA_CCE5, r_rdata returned for out-of-window reads

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- tcdm_req_i  in  N_PORT  request per port
- tcdm_add_i  in  N_PORT x 32  byte address per port
- tcdm_wen_i  in  N_PORT  1 = read, 0 = write
- tcdm_be_i  in  N_PORT x 4  byte enables
- tcdm_wdata_i  in  N_PORT x 32  write data
- tcdm_gnt_o  out  N_PORT  grant (combinational, same cycle as req)
- tcdm_r_valid_o  out  N_PORT  response valid
- tcdm_r_rdata_o  out  N_PORT x 32  response data
- mem_req_o  out  1  SRAM access enable
- mem_we_o  out  1  SRAM write enable (active high)
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address
- mem_be_o  out  4  SRAM byte enables
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o
- err_o  out  1  one-cycle pulse on any out-of-window access

Behaviour:
- Reset (rst_i high at a clock edge): the RR pointer goes to 0 and all pending responses are cleared. tcdm_r_valid_o=0, tcdm_r_rdata_o=0 and err_o=0 from the next cycle. tcdm_gnt_o and mem_req_o are forced to 0 while rst_i is high. A response pending when reset asserts is dropped and never delivered.

Arbitration:
- At most one grant per cycle.
- Winner is the first requesting port at or after the pointer, searching upward with wrap from N_PORT-1 to 0.
- After a grant the pointer becomes winner+1 mod N_PORT. With no grant the pointer holds.
- A non-granted port must hold req and payload stable. The block does not store losing requests.

Memory path:
- On a grant, if the address is in the window, mem_req_o=1 in the same cycle.
- mem_we_o = ~wen.
- mem_addr_o = (add - BASE_ADDR)[MEM_ADDR_WIDTH+1:2]. Low 2 address bits are ignored.
- mem_be_o and mem_wdata_o are taken from the winner.
- The window test is BASE_ADDR <= add < BASE_ADDR + 4*2**MEM_ADDR_WIDTH, computed with 33-bit unsigned arithmetic so that wrap past 2**32 counts as out-of-window.

Out-of-window access:
- Still granted; mem_req_o stays 0.
- err_o pulses in the response cycle.
- A read returns ERR_DATA. A write is discarded.

Response:
- Exactly one cycle after the grant, tcdm_r_valid_o[winner]=1 for one cycle, for reads and for writes.
- Read data is mem_rdata_i (or ERR_DATA). Write responses carry r_rdata=0.
- tcdm_r_rdata_o of every port without r_valid is 0.
- Latency from grant to r_valid is a fixed 1 cycle. Back-to-back grants every cycle are supported, giving full throughput of 1 access per cycle.

Simultaneous events:
- A response for grant N and grant N+1 to the same or another port occur in the same cycle without conflict.
- Two ports addressing the same word in consecutive cycles: the later access sees the earlier write, per SRAM write-then-read ordering.

Internal response state: a registered winner index, a valid bit and an err flag.

Test Plan:
- Single read: port 2 reads 0x1C01_0010 with mem[4]=0xCAFE_0004 -> gnt[2]=1 in the same cycle, mem_addr_o=4, r_valid[2]=1 and r_rdata[2]=0xCAFE_0004 next cycle.
- Byte write then read: port 0 writes 0xAABBCCDD with be=4'b0101 to 0x1C01_0000 (old value 0), then reads it -> mem_be_o=0101, write response r_rdata=0, read returns 0x00BB00DD.
- Round-robin fairness: all 4 ports request continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, each r_valid one cycle after its grant, mem_req_o high all 8 cycles.
- Out-of-window: port 1 reads 0x1C01_4000 (MEM_ADDR_WIDTH=12) -> gnt[1]=1, mem_req_o=0, next cycle r_valid[1]=1, r_rdata=0xBADA_CCE5, err_o=1. A write to 0x1C00_FFFC leaves the memory unchanged.
- Reset mid-operation: port 3 granted a read, rst_i high in the following cycle -> r_valid[3] stays 0 afterwards, RR pointer=0, and the next simultaneous requests from ports 1 and 3 grant port 1 first.
- Held loser: ports 0 and 1 request with pointer=1 -> port 1 granted, port 0 granted the next cycle with unchanged payload, responses on consecutive cycles.
